// File: rtl/eth_header_writer.sv
// eth_header_writer
//   Transmit-side Ethernet header rewriter. For every packet it pops one entry
//   from the upstream header-info FIFO. The entry supplies the next-hop MAC, the
//   output port and a drop flag. The block writes the next-hop MAC into the
//   destination address and the selected port's MAC into the source address,
//   or swallows the whole packet. Accepted words leave through one register
//   stage.
//
// Ports
//   clk, reset               system clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr    input word stream; in_rdy is the accept strobe
//   out_data/out_ctrl/out_wr output word stream; out_rdy is downstream ready
//   info_vld/info_rd         header-info FIFO not-empty / pop strobe
//   info_dst_mac             next-hop MAC written into DA
//   info_port_num            output queue; the MAC index is the upper bits
//   info_drop                discard the packet
//   mac_0..mac_3             per-port source MACs
//   num_pkts_sent/dropped    wrapping 32-bit packet counters
module eth_header_writer #(
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int NUM_QUEUES       = 8,
  parameter int NUM_QUEUES_WIDTH = $clog2(NUM_QUEUES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [CTRL_WIDTH-1:0]       in_ctrl,
  input  logic                        in_wr,
  output logic                        in_rdy,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [CTRL_WIDTH-1:0]       out_ctrl,
  output logic                        out_wr,
  input  logic                        out_rdy,
  input  logic                        info_vld,
  output logic                        info_rd,
  input  logic [47:0]                 info_dst_mac,
  input  logic [NUM_QUEUES_WIDTH-1:0] info_port_num,
  input  logic                        info_drop,
  input  logic [47:0]                 mac_0,
  input  logic [47:0]                 mac_1,
  input  logic [47:0]                 mac_2,
  input  logic [47:0]                 mac_3,
  output logic [31:0]                 num_pkts_sent,
  output logic [31:0]                 num_pkts_dropped
);

  typedef enum logic [1:0] {
    WAIT_INFO = 2'd0,
    MOD_HDRS  = 2'd1,
    WORD1     = 2'd2,
    PAYLOAD   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [47:0]             dst_mac_q, dst_mac_d;
  logic [47:0]             sa_q, sa_d;
  logic                    drop_q, drop_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q;
  logic                    out_wr_q;
  logic [31:0]             sent_cnt_q, drop_cnt_q;

  logic                    xfer;
  logic                    is_ctrl_word;
  logic                    pkt_done;
  logic [31:0]             mac_idx;
  logic [47:0]             sel_sa;

  assign xfer         = in_wr && in_rdy;
  assign is_ctrl_word = (in_ctrl != '0);

  // Source MAC lookup: MAC ports sit on even queue numbers, so the port index is
  // the queue number without its LSB; anything above port 3 folds onto mac_3.
  always_comb begin
    mac_idx = 32'(info_port_num >> 1);
    case (mac_idx)
      32'd0:   sel_sa = mac_0;
      32'd1:   sel_sa = mac_1;
      32'd2:   sel_sa = mac_2;
      default: sel_sa = mac_3;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_INFO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including the per-packet context latched on the pop
  always_comb begin
    state_d   = state_q;
    dst_mac_d = dst_mac_q;
    sa_d      = sa_q;
    drop_d    = drop_q;
    case (state_q)
      WAIT_INFO: begin
        if (info_rd) begin
          dst_mac_d = info_dst_mac;
          sa_d      = sel_sa;
          drop_d    = info_drop;
          state_d   = MOD_HDRS;
        end
      end
      MOD_HDRS: begin
        if (xfer && !is_ctrl_word) state_d = WORD1;
      end
      WORD1: begin
        // A two-word packet ends on word1.
        if (xfer) state_d = is_ctrl_word ? WAIT_INFO : PAYLOAD;
      end
      PAYLOAD: begin
        if (xfer && is_ctrl_word) state_d = WAIT_INFO;
      end
      default: state_d = WAIT_INFO;
    endcase
  end

  // Output logic. Strobes are masked while reset is held so that nothing is
  // popped or accepted before the state register has been cleared.
  always_comb begin
    in_rdy     = !reset && out_rdy && (state_q != WAIT_INFO);
    info_rd    = !reset && info_vld && (state_q == WAIT_INFO);
    pkt_done   = xfer && is_ctrl_word && ((state_q == WORD1) || (state_q == PAYLOAD));
    out_data_d = in_data;
    case (state_q)
      MOD_HDRS: if (!is_ctrl_word) out_data_d = {dst_mac_q, sa_q[47:32]};
      WORD1:    out_data_d = {sa_q[31:0], in_data[31:0]};
      default:  out_data_d = in_data;
    endcase
  end

  // Packet context, only meaningful after a pop
  always_ff @(posedge clk) begin
    dst_mac_q <= dst_mac_d;
    sa_q      <= sa_d;
    drop_q    <= drop_d;
  end

  // Output register stage and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_wr_q <= xfer && !drop_q;
      if (xfer) begin
        out_data_q <= out_data_d;
        out_ctrl_q <= in_ctrl;
      end
      if (pkt_done) begin
        if (drop_q) drop_cnt_q <= drop_cnt_q + 32'd1;
        else        sent_cnt_q <= sent_cnt_q + 32'd1;
      end
    end
  end

  assign out_wr           = out_wr_q;
  assign out_data         = out_data_q;
  assign out_ctrl         = out_ctrl_q;
  assign num_pkts_sent    = sent_cnt_q;
  assign num_pkts_dropped = drop_cnt_q;

endmodule

// File: tb/tb_eth_header_writer.sv
module tb_eth_header_writer;
  localparam int DW  = 64;
  localparam int CW  = 8;
  localparam int NQ  = 8;
  localparam int NQW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  in_data;
  logic [CW-1:0]  in_ctrl;
  logic           in_wr;
  logic           in_rdy;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_ctrl;
  logic           out_wr;
  logic           out_rdy;
  logic           info_vld;
  logic           info_rd;
  logic [47:0]    info_dst_mac;
  logic [NQW-1:0] info_port_num;
  logic           info_drop;
  logic [47:0]    mac_0, mac_1, mac_2, mac_3;
  logic [31:0]    num_pkts_sent, num_pkts_dropped;

  always #5 clk = ~clk;

  eth_header_writer #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .NUM_QUEUES_WIDTH(NQW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .info_vld(info_vld), .info_rd(info_rd), .info_dst_mac(info_dst_mac),
    .info_port_num(info_port_num), .info_drop(info_drop),
    .mac_0(mac_0), .mac_1(mac_1), .mac_2(mac_2), .mac_3(mac_3),
    .num_pkts_sent(num_pkts_sent), .num_pkts_dropped(num_pkts_dropped)
  );

  typedef struct packed {
    logic [47:0]    dst;
    logic [NQW-1:0] port;
    logic           drop;
  } info_t;

  info_t       info_q[$];
  logic [71:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int exp_pops = 0;
  int exp_sent = 0;
  int exp_drop = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [47:0] exp_sa(input logic [NQW-1:0] port);
    case (port >> 1)
      3'd0:    return mac_0;
      3'd1:    return mac_1;
      3'd2:    return mac_2;
      default: return mac_3;
    endcase
  endfunction

  // Header-info FIFO model: contents presented after each falling edge,
  // pop decided from info_rd just before the rising edge.
  initial begin
    info_vld      = 1'b0;
    info_dst_mac  = '0;
    info_port_num = '0;
    info_drop     = 1'b0;
    forever begin
      @(negedge clk);
      if (info_q.size() != 0) begin
        info_vld      = 1'b1;
        info_dst_mac  = info_q[0].dst;
        info_port_num = info_q[0].port;
        info_drop     = info_q[0].drop;
      end else begin
        info_vld = 1'b0;
      end
      #4;
      if (info_rd) begin
        if (info_q.size() != 0) void'(info_q.pop_front());
        pops++;
      end
    end
  end

  // Output scoreboard
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (out_wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_wr", 72'd1, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {out_ctrl, out_data}, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_info(input logic [47:0] dst, input logic [NQW-1:0] port, input bit drop);
    info_t t;
    t.dst = dst; t.port = port; t.drop = drop;
    info_q.push_back(t);
    exp_pops++;
  endtask

  // Sends nhdr module headers then ndata packet words; stops after nsend words.
  task automatic send_pkt(input int nhdr, input int ndata, input int nsend, input bit rnd,
                          input logic [47:0] dst, input logic [47:0] sa, input bit drop);
    int tot_w;
    tot_w = nhdr + ndata;
    for (int i = 0; i < tot_w && i < nsend; i++) begin
      logic [63:0] d, ed;
      logic [7:0]  c;
      int          tries;
      bit          got;
      d = {$urandom, $urandom};
      if (i < nhdr)            c = 8'hFF;
      else if (i == tot_w - 1) c = 8'h01;
      else                     c = 8'h00;
      ed = d;
      if (i == nhdr)          ed = {dst, sa[47:32]};
      else if (i == nhdr + 1) ed = {sa[31:0], d[31:0]};
      tries = 0;
      got   = 1'b0;
      while (!got && tries < 200) begin
        @(negedge clk);
        out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_wr   = 1'b0;
        #1;
        if (in_rdy) got = 1'b1;
        else tries++;
      end
      if (!got) begin
        check("in_rdy_timeout", 72'd0, 72'd1);
        return;
      end
      in_wr   = 1'b1;
      in_data = d;
      in_ctrl = c;
      if (!drop) exp_q.push_back({c, ed});
      #3;
      check("in_wr_only_with_rdy", 72'(in_rdy), 72'd1);
    end
    @(negedge clk);
    in_wr   = 1'b0;
    out_rdy = 1'b1;
    if (nsend >= tot_w) begin
      if (drop) exp_drop++;
      else      exp_sent++;
    end
  endtask

  task automatic drain_and_check(input string tag);
    repeat (3) @(negedge clk);
    #3;
    check({tag, "_drained"}, 72'(exp_q.size()), 72'd0);
    check({tag, "_sent"}, 72'(num_pkts_sent), 72'(exp_sent));
    check({tag, "_dropped"}, 72'(num_pkts_dropped), 72'(exp_drop));
    check({tag, "_pops"}, 72'(pops), 72'(exp_pops));
  endtask

  initial begin
    logic [47:0] dst1, dst2;
    logic [NQW-1:0] p;
    bit dr;
    dst1 = 48'h00AABBCCDDEE;
    dst2 = 48'h0200DEADBEEF;
    mac_0 = 48'h000A0B0C0D0E;
    mac_1 = 48'h001122334455;
    mac_2 = 48'h0066778899AA;
    mac_3 = 48'h00BBCCDDEEFF;
    reset   = 1'b1;
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("rst_out_wr",   72'(out_wr), 72'd0);
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst_info_rd",  72'(info_rd), 72'd0);
    check("rst_sent",     72'(num_pkts_sent), 72'd0);
    check("rst_dropped",  72'(num_pkts_dropped), 72'd0);
    check("rst_in_rdy",   72'(in_rdy), 72'd0);

    // 1: basic rewrite, port 2 selects mac_1
    push_info(dst1, 3'd2, 1'b0);
    send_pkt(1, 8, 99, 1'b0, dst1, mac_1, 1'b0);
    drain_and_check("t1");

    // 2: dropped packet followed by a forwarded one (port 0 -> mac_0)
    push_info(dst1, 3'd2, 1'b1);
    send_pkt(1, 8, 99, 1'b0, dst1, mac_1, 1'b1);
    push_info(dst2, 3'd0, 1'b0);
    send_pkt(1, 8, 99, 1'b0, dst2, mac_0, 1'b0);
    drain_and_check("t2");

    // 3: no info available -> no accept; accept begins the cycle after the pop
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("t3_no_info_in_rdy", 72'(in_rdy), 72'd0);
    end
    push_info(dst2, 3'd7, 1'b0);
    @(negedge clk);
    #2;
    check("t3_info_rd_pulse", 72'(info_rd), 72'd1);
    check("t3_in_rdy_during_pop", 72'(in_rdy), 72'd0);
    @(negedge clk);
    #2;
    check("t3_in_rdy_after_pop", 72'(in_rdy), 72'd1);
    check("t3_info_rd_single", 72'(info_rd), 72'd0);
    send_pkt(0, 2, 99, 1'b0, dst2, mac_3, 1'b0);
    drain_and_check("t3");

    // 4: 100 back-to-back packets with random back-pressure
    for (int i = 0; i < 100; i++) begin
      p  = NQW'(i % 8);
      dr = ((i % 9) == 4);
      push_info({16'h0A00, 32'(i)}, p, dr);
    end
    for (int i = 0; i < 100; i++) begin
      p  = NQW'(i % 8);
      dr = ((i % 9) == 4);
      send_pkt(i % 3, 2 + (i % 7), 99, 1'b1, {16'h0A00, 32'(i)}, exp_sa(p), dr);
    end
    drain_and_check("t4");

    // 5: reset in the middle of a packet, then a fresh packet
    push_info(dst1, 3'd4, 1'b0);
    send_pkt(1, 9, 4, 1'b0, dst1, mac_2, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("t5_out_wr_in_reset", 72'(out_wr), 72'd0);
    reset = 1'b0;
    exp_sent = 0;
    exp_drop = 0;
    push_info(dst2, 3'd6, 1'b0);
    send_pkt(1, 6, 99, 1'b0, dst2, mac_3, 1'b0);
    drain_and_check("t5");

    // 6: sent counter wraps
    @(negedge clk);
    force dut.sent_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.sent_cnt_q;
    #1;
    check("t6_preload", 72'(num_pkts_sent), 72'hFFFFFFFF);
    push_info(dst1, 3'd1, 1'b0);
    send_pkt(0, 3, 99, 1'b0, dst1, mac_0, 1'b0);
    exp_sent = 0;
    drain_and_check("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_header_writer.md
Name: eth_header_writer

Overview:
Transmit-side counterpart of the receive Ethernet parser. Sits in the user datapath after output-port lookup and before the output queues. For each packet it pops one header-info entry from the upstream lookup FIFO, overwrites the Ethernet destination MAC with the next-hop MAC and the source MAC with the selected port's MAC, or drops the packet, then forwards the stream with a single registered stage.

Parameters:
DATA_WIDTH, 64, datapath word width; only 64 is supported.
CTRL_WIDTH, 8, control word width (DATA_WIDTH/8).
NUM_QUEUES, 8, number of output queues, MAC and CPU interleaved.
NUM_QUEUES_WIDTH, log2(NUM_QUEUES), width of the port number.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
in_data  in  DATA_WIDTH  input packet word.
in_ctrl  in  CTRL_WIDTH  input control; nonzero marks a module header or the last word.
in_wr  in  1  input word valid.
in_rdy  out  1  block can accept an input word this cycle.
out_data  out  DATA_WIDTH  output packet word.
out_ctrl  out  CTRL_WIDTH  output control, passed through unchanged.
out_wr  out  1  output word valid.
out_rdy  in  1  downstream can accept a word.
info_vld  in  1  header-info entry available (FIFO not empty).
info_rd  out  1  pop strobe for the header-info entry, one cycle.
info_dst_mac  in  48  next-hop MAC to write into DA.
info_port_num  in  NUM_QUEUES_WIDTH  output port; the MAC index is info_port_num[NUM_QUEUES_WIDTH-1:1].
info_drop  in  1  discard the packet.
mac_0..mac_3  in  48 each  source MAC of ports 0..3.
num_pkts_sent  out  32  packets forwarded.
num_pkts_dropped  out  32  packets discarded.

Behaviour:
- Reset values: out_wr=0, out_data=0, out_ctrl=0, info_rd=0, both counters=0, state=WAIT_INFO.
- Word layout:
  - word0 is the first word with in_ctrl==0: DA[47:0] sits in bits [63:16]; SA[47:32] sits in [15:0].
  - word1 holds SA[31:0] in [63:32]; bits [31:0] pass through unchanged.
- Handshake:
  - A word transfers when in_wr && in_rdy.
  - in_rdy = out_rdy && state!=WAIT_INFO.
  - out_wr follows the transfer by exactly 1 cycle (registered), and only when the packet is not dropped.
  - in_wr is never asserted unless in_rdy is high; the bench checks this.
- States:
  - WAIT_INFO: in_rdy=0. When info_vld=1: latch dst_mac, the SA selected by port index (mac_0..mac_3; an index above 3 selects mac_3), and drop. Pulse info_rd for 1 cycle. Go to MOD_HDRS.
  - MOD_HDRS: pass header words (in_ctrl!=0) unchanged. A word with in_ctrl==0 is output as {dst_mac, sa[47:32]}, then go to WORD1.
  - WORD1: output {sa[31:0], in_data[31:0]}, then go to PAYLOAD.
  - PAYLOAD: pass words through. The first word with in_ctrl!=0 is the last word: increment the sent or dropped counter, then go to WAIT_INFO.
- A dropped packet is consumed at full rate with out_wr held at 0 throughout.
- Each info entry is popped exactly once per packet, before the packet's first word is accepted. Packets are never merged or split.
- Back-pressure: when out_rdy=0, no input word is accepted and out_wr is 0 on the following cycle. Output words are never lost or duplicated.
- Counters wrap at 2^32-1 → 0.
- Reset mid-packet: return to WAIT_INFO; the partial packet is abandoned and counters are cleared.
- Minimum packet is 2 data words, with word1 as the last word. A packet ending on word1 goes straight to WAIT_INFO after counting.

Test Plan:
1. Info {dst=0x00AABBCCDDEE, port=2, drop=0}, mac_1=0x001122334455, 1 module header + 8-word packet → out word0[63:16]=0x00AABBCCDDEE, word0[15:0]=0x0011, word1[63:32]=0x22334455; other bits unchanged; num_pkts_sent=1; info_rd pulsed once.
2. Same packet with drop=1 → out_wr stays 0 for the whole packet; num_pkts_dropped=1; next packet is forwarded normally.
3. Packet presented with info_vld=0 for 5 cycles → in_rdy stays 0; after info_vld rises, in_rdy goes high the cycle after info_rd.
4. Random out_rdy toggling at 50% over 100 back-to-back packets → output equals the expected rewritten stream word-for-word; 100 info pops.
5. Reset asserted at word 4 of a 10-word packet, then a new packet → only the new packet appears, correctly rewritten; counters equal 1/0.
6. Counter preloaded via force to 0xFFFFFFFF, then one packet sent → num_pkts_sent=0.
